// File: rtl/frame_bank_scheduler.sv
// rtl/frame_bank_scheduler.sv - double-buffer bank scheduler between a frame writer and a VGA reader
// Writer fills the back bank; the banks swap only at a reader frame boundary once a full frame is ready.
module frame_bank_scheduler #(
  parameter int RESOLUTION_WIDTH  = 640,
  parameter int RESOLUTION_HEIGHT = 480,
  localparam int N  = RESOLUTION_WIDTH * RESOLUTION_HEIGHT,
  localparam int AW = $clog2(N)
) (
  input  logic          pclk,
  input  logic          rst_n,
  input  logic          wr_frame_start,
  input  logic          wr_pixel_dv,
  input  logic          wr_frame_done,
  input  logic          rd_frame_start,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          wr_bank,
  output logic          rd_bank,
  output logic          rd_frame_valid,
  output logic [7:0]    dropped_frames,
  output logic [7:0]    short_frames
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] N_C    = CW'(N);
  localparam logic [AW-1:0] LAST_A = AW'(N - 1);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FILL = 2'd1,
    W_DONE = 2'd2
  } w_state_t;

  w_state_t      r_state;
  logic [CW-1:0] r_count;
  logic          r_rd_bank;
  logic          r_valid;
  logic [7:0]    r_dropped;
  logic [7:0]    r_short;

  logic          w_accept;
  logic [CW-1:0] w_count_next;

  // A restart cycle does not write: its pixel would belong to the abandoned frame.
  assign w_accept     = (r_state == W_FILL) && wr_pixel_dv && !wr_frame_start && (r_count < N_C);
  assign w_count_next = r_count + CW'(w_accept);

  assign wr_en          = w_accept;
  assign wr_addr        = (r_count >= N_C) ? LAST_A : r_count[AW-1:0];
  assign rd_bank        = r_rd_bank;
  assign wr_bank        = ~r_rd_bank;
  assign rd_frame_valid = r_valid;
  assign dropped_frames = r_dropped;
  assign short_frames   = r_short;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= W_IDLE;
      r_count   <= '0;
      r_rd_bank <= 1'b0;
      r_valid   <= 1'b0;
      r_dropped <= 8'd0;
      r_short   <= 8'd0;
    end else begin
      case (r_state)
        W_IDLE: begin
          if (wr_frame_start) begin
            r_state <= W_FILL;
            r_count <= '0;
          end
        end
        W_FILL: begin
          if (wr_frame_start) begin
            r_count <= '0;
            r_short <= sat_inc(r_short);
          end else begin
            r_count <= w_count_next;
            if (wr_frame_done) begin
              if (w_count_next == N_C) begin
                r_state <= W_DONE;
              end else begin
                r_state <= W_IDLE;
                r_short <= sat_inc(r_short);
              end
            end
          end
        end
        W_DONE: begin
          if (rd_frame_start) begin
            r_rd_bank <= ~r_rd_bank;
            r_valid   <= 1'b1;
            if (wr_frame_start) begin
              r_state <= W_FILL;
              r_count <= '0;
            end else begin
              r_state <= W_IDLE;
            end
          end else if (wr_frame_start) begin
            r_dropped <= sat_inc(r_dropped);
            r_state   <= W_FILL;
            r_count   <= '0;
          end
        end
        default: begin
          r_state <= W_IDLE;
          r_count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// tb/tb_frame_bank_scheduler.sv - directed vector bench for frame_bank_scheduler with N=8
module tb_frame_bank_scheduler;

  logic       pclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_frame_start = 1'b0;
  logic       wr_pixel_dv = 1'b0;
  logic       wr_frame_done = 1'b0;
  logic       rd_frame_start = 1'b0;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic       wr_bank;
  logic       rd_bank;
  logic       rd_frame_valid;
  logic [7:0] dropped_frames;
  logic [7:0] short_frames;

  frame_bank_scheduler #(
    .RESOLUTION_WIDTH (4),
    .RESOLUTION_HEIGHT(2)
  ) dut (
    .pclk          (pclk),
    .rst_n         (rst_n),
    .wr_frame_start(wr_frame_start),
    .wr_pixel_dv   (wr_pixel_dv),
    .wr_frame_done (wr_frame_done),
    .rd_frame_start(rd_frame_start),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_bank       (wr_bank),
    .rd_bank       (rd_bank),
    .rd_frame_valid(rd_frame_valid),
    .dropped_frames(dropped_frames),
    .short_frames  (short_frames)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    bit fs, dv, fd, rs;
    bit en;
    int addr;
    bit rb, vld;
    int drp, sht;
  } vec_t;

  vec_t vq[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input bit fs, input bit dv, input bit fd, input bit rs,
                     input bit en, input int addr, input bit rb, input bit vld,
                     input int drp, input int sht);
    vec_t v;
    v.fs = fs; v.dv = dv; v.fd = fd; v.rs = rs;
    v.en = en; v.addr = addr; v.rb = rb; v.vld = vld; v.drp = drp; v.sht = sht;
    vq.push_back(v);
  endtask

  task automatic drive(input bit fs, input bit dv, input bit fd, input bit rs);
    wr_frame_start = fs;
    wr_pixel_dv    = dv;
    wr_frame_done  = fd;
    rd_frame_start = rs;
  endtask

  initial begin
    // full frame then swap
    add(1,0,0,0, 0,0, 0,0, 0,0);
    for (int i = 0; i < 8; i++) add(0,1,0,0, 1,i, 0,0, 0,0);
    add(0,0,1,0, 0,7, 0,0, 0,0);
    add(0,0,0,1, 0,7, 1,1, 0,0);
    add(0,1,0,0, 0,7, 1,1, 0,0);
    // short frame of 5, reader boundaries mid-fill and in idle do not swap
    add(1,0,0,0, 0,7, 1,1, 0,0);
    for (int i = 0; i < 5; i++) add(0,1,0,0, 1,i, 1,1, 0,0);
    add(0,0,0,1, 0,5, 1,1, 0,0);
    add(0,0,1,0, 0,5, 1,1, 0,1);
    add(0,1,0,0, 0,5, 1,1, 0,1);
    add(0,0,0,1, 0,5, 1,1, 0,1);
    // full frame, then new writer frame before reader boundary -> drop
    add(1,0,0,0, 0,5, 1,1, 0,1);
    for (int i = 0; i < 8; i++) add(0,1,0,0, 1,i, 1,1, 0,1);
    add(0,0,1,0, 0,7, 1,1, 0,1);
    add(1,0,0,0, 0,7, 1,1, 1,1);
    for (int i = 0; i < 7; i++) add(0,1,0,0, 1,i, 1,1, 1,1);
    add(0,1,1,0, 1,7, 1,1, 1,1);
    // swap and restart in the same cycle
    add(1,0,0,1, 0,7, 0,1, 1,1);
    // overflow pixels are dropped
    for (int i = 0; i < 8; i++) add(0,1,0,0, 1,i, 0,1, 1,1);
    add(0,1,0,0, 0,7, 0,1, 1,1);
    add(0,1,0,0, 0,7, 0,1, 1,1);
    add(0,0,1,0, 0,7, 0,1, 1,1);
    add(0,0,0,1, 0,7, 1,1, 1,1);
    // restart mid-frame counts as short
    add(1,0,0,0, 0,7, 1,1, 1,1);
    for (int i = 0; i < 3; i++) add(0,1,0,0, 1,i, 1,1, 1,1);
    add(1,1,0,0, 0,3, 1,1, 1,2);
    add(0,1,0,0, 1,0, 1,1, 1,2);
    add(0,1,0,0, 1,1, 1,1, 1,2);

    #2;
    chk("rst wr_en", wr_en, 0);
    chk("rst wr_addr", wr_addr, 0);
    chk("rst rd_bank", rd_bank, 0);
    chk("rst wr_bank", wr_bank, 1);
    chk("rst valid", rd_frame_valid, 0);
    chk("rst dropped", dropped_frames, 0);
    chk("rst short", short_frames, 0);
    @(negedge pclk);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      @(negedge pclk);
      drive(vq[i].fs, vq[i].dv, vq[i].fd, vq[i].rs);
      #1;
      chk($sformatf("v%0d wr_en", i), wr_en, vq[i].en);
      chk($sformatf("v%0d wr_addr", i), wr_addr, vq[i].addr);
      @(posedge pclk);
      #1;
      chk($sformatf("v%0d rd_bank", i), rd_bank, vq[i].rb);
      chk($sformatf("v%0d wr_bank", i), wr_bank, !vq[i].rb);
      chk($sformatf("v%0d valid", i), rd_frame_valid, vq[i].vld);
      chk($sformatf("v%0d dropped", i), dropped_frames, vq[i].drp);
      chk($sformatf("v%0d short", i), short_frames, vq[i].sht);
    end

    // reset mid-frame acts immediately and bumps no counter
    @(negedge pclk);
    drive(0, 1, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst wr_en", wr_en, 0);
    chk("midrst wr_addr", wr_addr, 0);
    chk("midrst rd_bank", rd_bank, 0);
    chk("midrst wr_bank", wr_bank, 1);
    chk("midrst valid", rd_frame_valid, 0);
    chk("midrst dropped", dropped_frames, 0);
    chk("midrst short", short_frames, 0);
    @(negedge pclk);
    rst_n = 1'b1;
    #1;
    chk("post-rst dv ignored", wr_en, 0);
    @(posedge pclk);
    #1;
    chk("post-rst short", short_frames, 0);

    // short-frame counter saturates
    for (int k = 0; k < 300; k++) begin
      @(negedge pclk);
      drive(1, 0, 0, 0);
      @(negedge pclk);
      drive(0, 0, 1, 0);
      if (k == 253) begin
        @(posedge pclk);
        #1;
        chk("short at 254", short_frames, 254);
      end
    end
    @(negedge pclk);
    drive(0, 0, 0, 0);
    #1;
    chk("short saturated", short_frames, 255);
    chk("dropped after shorts", dropped_frames, 0);
    chk("rd_bank after shorts", rd_bank, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
